// File: rtl/cs8900_io_master_if.sv
// ----------------------------------------------------------------------------
// cs8900_io_master_if
// Request/response interface between the Zorro III side logic and the
// CS8900A 8-bit I/O cycle generator.
//   req    : request, sampled by the slave only while busy=0
//   we     : 1 = write, 0 = read
//   addr   : word address (becomes sa[3:1])
//   be     : byte enables, be[0] = low byte, be[1] = high byte
//   wdata  : write data, [7:0] low byte, [15:8] high byte
//   rdata  : read data, valid in the ack cycle, held until the next ack
//   ack    : one-cycle completion pulse
//   busy   : high from the cycle after accept through the ack cycle
// Modports: master = requester (Zorro side), slave = cycle generator.
// ----------------------------------------------------------------------------
interface cs8900_io_master_if;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  rdata,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output rdata,
        output ack,
        output busy
    );
endinterface

// File: rtl/cs8900_io_master.sv
// ----------------------------------------------------------------------------
// cs8900_io_master
// Turns a 16-bit word request into one or two timed 8-bit ISA I/O cycles
// (nIOR/nIOW) on the CS8900A bus, low byte first, assembles the read data and
// returns a single-cycle ack.
// Ports:
//   clk      : clock
//   reset    : synchronous, active-high reset
//   bus      : request/response interface (slave modport)
//   o_sa     : chip address {addr, byte select}
//   i_sd_i   : chip data bus input
//   o_sd_o   : chip data bus output
//   o_sd_oe  : chip data bus output enable
//   o_nior   : read strobe, active low
//   o_niow   : write strobe, active low
// Parameters (cycles, 1..255): T_SETUP, T_ACTIVE, T_HOLD, T_RECOVERY.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module cs8900_io_master #(
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_ACTIVE   = 16,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_RECOVERY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    cs8900_io_master_if.slave        bus,
    output logic [3:0]               o_sa,
    input  logic [7:0]               i_sd_i,
    output logic [7:0]               o_sd_o,
    output logic                     o_sd_oe,
    output logic                     o_nior,
    output logic                     o_niow
);

    // The phase counter is loaded with (length - 1) and the phase ends when it
    // reads zero, so a phase of length N lasts exactly N cycles.
    localparam logic [7:0] L_SETUP    = 8'(T_SETUP - 1);
    localparam logic [7:0] L_ACTIVE   = 8'(T_ACTIVE - 1);
    localparam logic [7:0] L_HOLD     = 8'(T_HOLD - 1);
    localparam logic [7:0] L_RECOVERY = 8'(T_RECOVERY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecov,
        StDone
    } state_e;

    state_e      r_state,  w_state_d;
    logic [7:0]  r_cnt,    w_cnt_d;
    logic        r_we,     w_we_d;
    logic [2:0]  r_addr,   w_addr_d;
    logic        r_be_hi,  w_be_hi_d;
    logic [15:0] r_wdata,  w_wdata_d;
    logic        r_hi,     w_hi_d;      // byte currently on the bus: 0 = low, 1 = high
    logic [15:0] r_rbuf,   w_rbuf_d;    // read data being assembled
    logic [15:0] r_rdata,  w_rdata_d;   // read data presented to the requester
    logic        r_ack,    w_ack_d;
    logic        r_busy,   w_busy_d;
    logic [3:0]  r_sa,     w_sa_d;
    logic [7:0]  r_sd_o,   w_sd_o_d;
    logic        r_sd_oe,  w_sd_oe_d;
    logic        r_nior,   w_nior_d;
    logic        r_niow,   w_niow_d;

    logic        w_last;
    logic        w_on_bus;

    assign w_last = (r_cnt == 8'd0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_we_d    = r_we;
        w_addr_d  = r_addr;
        w_be_hi_d = r_be_hi;
        w_wdata_d = r_wdata;
        w_hi_d    = r_hi;
        w_rbuf_d  = r_rbuf;

        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    w_we_d    = bus.we;
                    w_addr_d  = bus.addr;
                    w_be_hi_d = bus.be[1];
                    w_wdata_d = bus.wdata;
                    // Bytes that are not read stay 0x00 in the returned word.
                    w_rbuf_d  = 16'h0000;
                    w_hi_d    = ~bus.be[0];
                    if (bus.be == 2'b00) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StSetup;
                        w_cnt_d   = L_SETUP;
                    end
                end
            end

            StSetup: begin
                if (w_last) begin
                    w_state_d = StStrobe;
                    w_cnt_d   = L_ACTIVE;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end

            StStrobe: begin
                if (w_last) begin
                    // Sample on the last strobe-low cycle, when SD has had the
                    // full active time to settle.
                    if (!r_we) begin
                        if (r_hi) begin
                            w_rbuf_d[15:8] = i_sd_i;
                        end else begin
                            w_rbuf_d[7:0] = i_sd_i;
                        end
                    end
                    w_state_d = StHold;
                    w_cnt_d   = L_HOLD;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end

            StHold: begin
                if (w_last) begin
                    if (!r_hi && r_be_hi) begin
                        w_state_d = StRecov;
                        w_cnt_d   = L_RECOVERY;
                        w_hi_d    = 1'b1;
                    end else begin
                        w_state_d = StDone;
                    end
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end

            StRecov: begin
                if (w_last) begin
                    w_state_d = StSetup;
                    w_cnt_d   = L_SETUP;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end

            StDone: begin
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output next values, decoded from the next state so every pin is a flop
    // that changes on the same edge as the state it belongs to.
    // ------------------------------------------------------------------------
    always_comb begin
        w_on_bus  = (w_state_d == StSetup) || (w_state_d == StStrobe) ||
                    (w_state_d == StHold);
        w_ack_d   = (w_state_d == StDone);
        w_busy_d  = (w_state_d != StIdle);
        w_nior_d  = !((w_state_d == StStrobe) && !w_we_d);
        w_niow_d  = !((w_state_d == StStrobe) && w_we_d);
        w_sd_oe_d = w_on_bus && w_we_d;

        w_sa_d = r_sa;
        if (w_on_bus || (w_state_d == StRecov)) begin
            w_sa_d = {w_addr_d, w_hi_d};
        end

        w_sd_o_d = r_sd_o;
        if (w_we_d && (w_state_d == StSetup)) begin
            w_sd_o_d = w_hi_d ? w_wdata_d[15:8] : w_wdata_d[7:0];
        end

        w_rdata_d = r_rdata;
        if (w_state_d == StDone) begin
            w_rdata_d = w_rbuf_d;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= 3'd0;
            r_be_hi <= 1'b0;
            r_wdata <= 16'h0000;
            r_hi    <= 1'b0;
            r_rbuf  <= 16'h0000;
            r_rdata <= 16'h0000;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_sa    <= 4'h0;
            r_sd_o  <= 8'h00;
            r_sd_oe <= 1'b0;
            r_nior  <= 1'b1;
            r_niow  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_we    <= w_we_d;
            r_addr  <= w_addr_d;
            r_be_hi <= w_be_hi_d;
            r_wdata <= w_wdata_d;
            r_hi    <= w_hi_d;
            r_rbuf  <= w_rbuf_d;
            r_rdata <= w_rdata_d;
            r_ack   <= w_ack_d;
            r_busy  <= w_busy_d;
            r_sa    <= w_sa_d;
            r_sd_o  <= w_sd_o_d;
            r_sd_oe <= w_sd_oe_d;
            r_nior  <= w_nior_d;
            r_niow  <= w_niow_d;
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.busy  = r_busy;
    assign o_sa      = r_sa;
    assign o_sd_o    = r_sd_o;
    assign o_sd_oe   = r_sd_oe;
    assign o_nior    = r_nior;
    assign o_niow    = r_niow;

endmodule

// File: doc/cs8900_io_master.md
# cs8900_io_master

Initiator-side ISA I/O cycle generator for the CS8900A Ethernet controller in 8-bit mode. It accepts a 16-bit word request (word address, byte enables, direction, write data) from the Zorro III side logic. It issues one or two timed 8-bit nIOR/nIOW cycles on the CS8900A bus, low byte first, assembles read data, and returns a single-cycle ack. It drives the address, data, and strobe pins of the chip directly.

## Interface
- T_SETUP, 2: cycles SA/SD valid before strobe falls (1..255)
- T_ACTIVE, 16: cycles strobe held low; covers 135 ns IOR-to-SD-valid (1..255)
- T_HOLD, 2: cycles SA/SD held after strobe rises (1..255)
- T_RECOVERY, 4: idle cycles between the two byte cycles of one request (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  1  request; sampled only while busy=0
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  3  word address; drives sa[3:1]
- be  in  2  byte enables; be[0] = low byte (sa[0]=0), be[1] = high byte (sa[0]=1)
- wdata  in  16  write data; [7:0] low byte, [15:8] high byte
- rdata  out  16  read data; valid in the ack cycle, held until next ack
- ack  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after accept through the ack cycle
- sa  out  4  chip address {addr, byte select}
- sd_i  in  8  chip data bus input
- sd_o  out  8  chip data bus output
- sd_oe  out  1  data bus output enable
- nior  out  1  read strobe, active low
- niow  out  1  write strobe, active low

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOV, DONE. One 8-bit down-counter is loaded with the phase length on each state entry.
- IDLE:
  - If req=1, latch we, addr, be, and wdata; clear rdata bytes not enabled to 0x00.
  - Select the first byte: low byte if be[0], else high byte.
  - Go to SETUP. If be=00, go directly to DONE with no bus cycle.
- SETUP (T_SETUP cycles):
  - sa = {addr, byte select}.
  - On a write, sd_oe=1 and sd_o = the selected byte.
- STROBE (T_ACTIVE cycles):
  - nior (read) or niow (write) = 0; sa, sd_o, and sd_oe are unchanged.
  - On a read, sample sd_i into the selected rdata byte on the final STROBE cycle.
- HOLD (T_HOLD cycles): both strobes = 1; sa, sd_o, and sd_oe are unchanged.
- After HOLD:
  - If the low byte was just done and be[1]=1, go to RECOV.
  - Otherwise go to DONE.
- RECOV (T_RECOVERY cycles):
  - sd_oe=0; sa[0] switches to 1.
  - Then go to SETUP for the high byte.
- DONE: ack=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE). req while busy=1 is ignored. The earliest next accept is the cycle after ack.
- nior and niow are never low simultaneously. No strobe is asserted outside STROBE.

## Timing
- Accept edge is cycle 0; SETUP occupies cycles 1..T_SETUP.
- Single-byte request:
  - Strobe low during cycles T_SETUP+1 .. T_SETUP+T_ACTIVE.
  - ack in cycle T_SETUP+T_ACTIVE+T_HOLD+1; with defaults, strobe low in cycles 3..18 and ack in cycle 21.
- Two-byte request:
  - ack is T_RECOVERY+T_SETUP+T_ACTIVE+T_HOLD cycles later than single-byte; with defaults, cycle 45.
  - High-byte strobe is low in cycles 27..42.
- be=00: ack in cycle 1.
- Reset values:
  - nior=1, niow=1, sd_oe=0, sd_o=0, sa=0, rdata=0, ack=0, busy=0, state IDLE.
- Reset mid-cycle: strobes and sd_oe deassert on the reset edge; no ack for the aborted request.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Read, addr=3'b101, be=01, sd_i=0x5A during strobe (defaults) -> sa=4'b1010; nior low cycles 3..18; niow stays 1; ack in cycle 21 with rdata=0x005A.
- Write, addr=0, be=11, wdata=0xBEEF:
  - sd_oe=1 with sd_o=0xEF, sa=0000, niow low cycles 3..18.
  - sd_oe=0 during RECOV.
  - sd_o=0xBE, sa=0001, niow low cycles 27..42.
  - ack in cycle 45.
- Read be=10, sd_i=0x33 -> only the high-byte cycle (sa[0]=1); rdata=0x3300; ack in cycle 21.
- be=00 -> no strobes, ack in cycle 1; req held high during a busy request -> no second accept until the cycle after ack.
- Assert reset in cycle 10 of a write -> niow=1 and sd_oe=0 next cycle; no ack; a new request afterwards completes normally.
- Parameter sweep T_SETUP=1, T_ACTIVE=1, T_HOLD=1 -> single-byte ack in cycle 4; strobes are never low simultaneously (checked by assertion).
